// File: rtl/ctrl_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, ALU codes,
// FSM states, IR field positions and opcode classification helpers.
package ctrl_pkg;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_AND  = 5'b00101;
   localparam logic [4:0] OP_OR   = 5'b00110;
   localparam logic [4:0] OP_SHR  = 5'b00111;
   localparam logic [4:0] OP_SHL  = 5'b01000;
   localparam logic [4:0] OP_ROR  = 5'b01001;
   localparam logic [4:0] OP_ROL  = 5'b01010;
   localparam logic [4:0] OP_MUL  = 5'b01011;
   localparam logic [4:0] OP_DIV  = 5'b01100;
   localparam logic [4:0] OP_NEG  = 5'b01101;
   localparam logic [4:0] OP_NOT  = 5'b01110;
   localparam logic [4:0] OP_NOP  = 5'b11010;
   localparam logic [4:0] OP_HALT = 5'b11011;

   localparam logic [3:0] ALU_AND = 4'h0;
   localparam logic [3:0] ALU_OR  = 4'h1;
   localparam logic [3:0] ALU_ADD = 4'h2;
   localparam logic [3:0] ALU_SUB = 4'h3;
   localparam logic [3:0] ALU_SHR = 4'h4;
   localparam logic [3:0] ALU_SHL = 4'h5;
   localparam logic [3:0] ALU_ROR = 4'h6;
   localparam logic [3:0] ALU_ROL = 4'h7;
   localparam logic [3:0] ALU_MUL = 4'h8;
   localparam logic [3:0] ALU_DIV = 4'h9;
   localparam logic [3:0] ALU_NEG = 4'hA;
   localparam logic [3:0] ALU_NOT = 4'hB;

   localparam int OP_MSB = 31;
   localparam int OP_LSB = 27;
   localparam int RA_MSB = 26;
   localparam int RA_LSB = 23;
   localparam int RB_MSB = 22;
   localparam int RB_LSB = 19;
   localparam int RC_MSB = 18;
   localparam int RC_LSB = 15;

   typedef enum logic [3:0] {
      IDLE, T0, T1, T2, T3, T4, T5, T6, HALTED
   } state_t;

   // Groups opcodes by the step sequence they follow after fetch.
   typedef enum logic [2:0] {
      CL_ALU, CL_MULDIV, CL_UNARY, CL_NOP, CL_HALT, CL_ILLEGAL
   } op_class_t;

   function automatic op_class_t op_class(input logic [4:0] op);
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR,
         OP_SHR, OP_SHL, OP_ROR, OP_ROL: op_class = CL_ALU;
         OP_MUL, OP_DIV:                 op_class = CL_MULDIV;
         OP_NEG, OP_NOT:                 op_class = CL_UNARY;
         OP_NOP:                         op_class = CL_NOP;
         OP_HALT:                        op_class = CL_HALT;
         default:                        op_class = CL_ILLEGAL;
      endcase
   endfunction

   function automatic logic [3:0] op_to_alu(input logic [4:0] op);
      case (op)
         OP_ADD:  op_to_alu = ALU_ADD;
         OP_SUB:  op_to_alu = ALU_SUB;
         OP_AND:  op_to_alu = ALU_AND;
         OP_OR:   op_to_alu = ALU_OR;
         OP_SHR:  op_to_alu = ALU_SHR;
         OP_SHL:  op_to_alu = ALU_SHL;
         OP_ROR:  op_to_alu = ALU_ROR;
         OP_ROL:  op_to_alu = ALU_ROL;
         OP_MUL:  op_to_alu = ALU_MUL;
         OP_DIV:  op_to_alu = ALU_DIV;
         OP_NEG:  op_to_alu = ALU_NEG;
         OP_NOT:  op_to_alu = ALU_NOT;
         default: op_to_alu = ALU_AND;
      endcase
   endfunction

endpackage

// File: rtl/reg_decode4to16.sv
// One-hot register select decoder; all outputs low when disabled.
module reg_decode4to16 (
   input  logic        i_en,
   input  logic [3:0]  i_sel,
   output logic [15:0] o_onehot
);

   genvar gi;
   generate
      for (gi = 0; gi < 16; gi++) begin : g_dec
         assign o_onehot[gi] = i_en && (i_sel == 4'(gi));
      end
   endgenerate

endmodule

// File: rtl/ctrl_sequencer.sv
// Hardwired Moore control unit sequencing fetch and register-register ALU
// instructions over a single-bus datapath, one bus transfer per clock.
module ctrl_sequencer
   import ctrl_pkg::*;
#(
   parameter int WAIT_LIMIT = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        run,
   input  logic        mem_ready,
   input  logic [31:0] ir,
   output logic        pc_out,
   output logic        pc_in,
   output logic        inc_pc,
   output logic        mar_in,
   output logic        read,
   output logic        mdr_in,
   output logic        mdr_out,
   output logic        ir_in,
   output logic        y_in,
   output logic        z_in,
   output logic        z_low_out,
   output logic        z_high_out,
   output logic        hi_in,
   output logic        lo_in,
   output logic [15:0] gpr_in,
   output logic [15:0] gpr_out,
   output logic [3:0]  alu_op,
   output logic        halted,
   output logic        fetch_err,
   output logic        illegal_op
);

   localparam int CW = $clog2(WAIT_LIMIT + 1);

   state_t          r_state, w_next;
   logic [CW-1:0]   r_wait_cnt, w_wait_next, w_wait_inc;
   logic            r_fetch_err, w_fetch_err_next;
   logic [4:0]      w_op;
   logic [3:0]      w_ra, w_rb, w_rc, w_gout_sel;
   op_class_t       w_class;
   state_t          w_end;
   logic            w_gin_en, w_gout_en;
   logic            w_unused_ir;

   assign w_op        = ir[OP_MSB:OP_LSB];
   assign w_ra        = ir[RA_MSB:RA_LSB];
   assign w_rb        = ir[RB_MSB:RB_LSB];
   assign w_rc        = ir[RC_MSB:RC_LSB];
   assign w_unused_ir = ^ir[RC_LSB-1:0];
   assign w_class     = op_class(w_op);
   assign w_wait_inc  = r_wait_cnt + CW'(1);
   assign w_end       = run ? T0 : IDLE;
   assign fetch_err   = r_fetch_err;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= IDLE;
         r_wait_cnt  <= '0;
         r_fetch_err <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_wait_cnt  <= w_wait_next;
         r_fetch_err <= w_fetch_err_next;
      end
   end

   always_comb begin
      w_next           = r_state;
      w_wait_next      = r_wait_cnt;
      w_fetch_err_next = r_fetch_err;
      pc_out     = 1'b0;
      pc_in      = 1'b0;
      inc_pc     = 1'b0;
      mar_in     = 1'b0;
      read       = 1'b0;
      mdr_in     = 1'b0;
      mdr_out    = 1'b0;
      ir_in      = 1'b0;
      y_in       = 1'b0;
      z_in       = 1'b0;
      z_low_out  = 1'b0;
      z_high_out = 1'b0;
      hi_in      = 1'b0;
      lo_in      = 1'b0;
      alu_op     = ALU_AND;
      halted     = 1'b0;
      illegal_op = 1'b0;
      w_gin_en   = 1'b0;
      w_gout_en  = 1'b0;
      w_gout_sel = w_rb;

      case (r_state)
         IDLE: if (run) w_next = T0;
         T0: begin
            pc_out = 1'b1;
            mar_in = 1'b1;
            inc_pc = 1'b1;
            z_in   = 1'b1;
            alu_op = ALU_ADD;
            w_next = T1;
         end
         T1: begin
            z_low_out = 1'b1;
            pc_in     = 1'b1;
            read      = 1'b1;
            mdr_in    = 1'b1;
            if (mem_ready) begin
               w_next = T2;
            end else begin
               w_wait_next = w_wait_inc;
               if (w_wait_inc == CW'(WAIT_LIMIT)) begin
                  w_next           = HALTED;
                  w_fetch_err_next = 1'b1;
               end
            end
         end
         T2: begin
            mdr_out = 1'b1;
            ir_in   = 1'b1;
            w_next  = T3;
         end
         T3: begin
            case (w_class)
               CL_ALU, CL_MULDIV: begin
                  w_gout_en = 1'b1;
                  y_in      = 1'b1;
                  w_next    = T4;
               end
               CL_UNARY: begin
                  w_gout_en = 1'b1;
                  z_in      = 1'b1;
                  alu_op    = op_to_alu(w_op);
                  w_next    = T4;
               end
               CL_HALT: w_next = HALTED;
               CL_ILLEGAL: begin
                  illegal_op = 1'b1;
                  w_next     = w_end;
               end
               default: w_next = w_end;
            endcase
         end
         T4: begin
            if (w_class == CL_UNARY) begin
               z_low_out = 1'b1;
               w_gin_en  = 1'b1;
               w_next    = w_end;
            end else begin
               w_gout_en  = 1'b1;
               w_gout_sel = w_rc;
               z_in       = 1'b1;
               alu_op     = op_to_alu(w_op);
               w_next     = T5;
            end
         end
         T5: begin
            z_low_out = 1'b1;
            if (w_class == CL_MULDIV) begin
               lo_in  = 1'b1;
               w_next = T6;
            end else begin
               w_gin_en = 1'b1;
               w_next   = w_end;
            end
         end
         T6: begin
            z_high_out = 1'b1;
            hi_in      = 1'b1;
            w_next     = w_end;
         end
         HALTED: halted = 1'b1;
         default: w_next = IDLE;
      endcase

      // Every fetch starts with a fresh memory wait budget.
      if (w_next == T0) w_wait_next = '0;
   end

   reg_decode4to16 u_dec_gpr_in (
      .i_en     (w_gin_en),
      .i_sel    (w_ra),
      .o_onehot (gpr_in)
   );

   reg_decode4to16 u_dec_gpr_out (
      .i_en     (w_gout_en),
      .i_sel    (w_gout_sel),
      .o_onehot (gpr_out)
   );

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer: per-cycle comparison of every output
// against hand-derived step sequences.
module tb_ctrl_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        run = 1'b0;
   logic        mem_ready = 1'b1;
   logic [31:0] ir = '0;
   logic pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in;
   logic y_in, z_in, z_low_out, z_high_out, hi_in, lo_in;
   logic [15:0] gpr_in, gpr_out;
   logic [3:0]  alu_op;
   logic        halted, fetch_err, illegal_op;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [13:0] B_PC_OUT = 14'h2000, B_PC_IN = 14'h1000, B_INC = 14'h0800,
                           B_MAR = 14'h0400, B_READ = 14'h0200, B_MDR_IN = 14'h0100,
                           B_MDR_OUT = 14'h0080, B_IR_IN = 14'h0040, B_Y_IN = 14'h0020,
                           B_Z_IN = 14'h0010, B_ZLO = 14'h0008, B_ZHI = 14'h0004,
                           B_HI = 14'h0002, B_LO = 14'h0001;

   ctrl_sequencer #(.WAIT_LIMIT(16)) dut (
      .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .ir(ir),
      .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
      .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
      .y_in(y_in), .z_in(z_in), .z_low_out(z_low_out), .z_high_out(z_high_out),
      .hi_in(hi_in), .lo_in(lo_in), .gpr_in(gpr_in), .gpr_out(gpr_out),
      .alu_op(alu_op), .halted(halted), .fetch_err(fetch_err), .illegal_op(illegal_op)
   );

   always #5 clk = ~clk;

   logic [13:0] strb;
   logic [52:0] obs;
   assign strb = {pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in,
                  y_in, z_in, z_low_out, z_high_out, hi_in, lo_in};
   assign obs  = {strb, gpr_in, gpr_out, alu_op, halted, fetch_err, illegal_op};

   function automatic logic [52:0] ex(input logic [13:0] s, input logic [15:0] gi,
                                      input logic [15:0] go, input logic [3:0] a,
                                      input logic h, input logic fe, input logic il);
      return {s, gi, go, a, h, fe, il};
   endfunction

   function automatic logic [52:0] fetch_step(input int i);
      case (i)
         0:       return ex(B_PC_OUT | B_MAR | B_INC | B_Z_IN, 16'h0, 16'h0, 4'h2, 1'b0, 1'b0, 1'b0);
         1:       return ex(B_ZLO | B_PC_IN | B_READ | B_MDR_IN, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
         default: return ex(B_MDR_OUT | B_IR_IN, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0);
      endcase
   endfunction

   task automatic do_reset();
      reset = 1'b1;
      run = 1'b0;
      mem_ready = 1'b1;
      ir = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      run = 1'b1;
      @(negedge clk);
      n_checks++;
      if (obs !== 53'h0) $display("FAIL reset_active: got %h expected %h", obs, 53'h0);
      if (obs !== 53'h0) n_fail++;
      run = 1'b0;
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== 53'h0) begin
            $display("FAIL reset_idle cycle %0d: got %h expected %h", i, obs, 53'h0);
            n_fail++;
         end
      end
   endtask

   task automatic test_add();
      logic [52:0] e[$];
      do_reset();
      ir = 32'h1A920000;
      run = 1'b1;
      e = {fetch_step(0), fetch_step(1), fetch_step(2),
           ex(B_Y_IN, 16'h0, 16'h0004, 4'h0, 1'b0, 1'b0, 1'b0),
           ex(B_Z_IN, 16'h0, 16'h0010, 4'h2, 1'b0, 1'b0, 1'b0),
           ex(B_ZLO, 16'h0020, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0),
           fetch_step(0)};
      for (int i = 0; i < e.size(); i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== e[i]) begin
            $display("FAIL add cycle %0d: got %h expected %h", i, obs, e[i]);
            n_fail++;
         end
      end
   endtask

   task automatic test_mem_wait();
      logic [52:0] e[$];
      do_reset();
      ir = 32'h1A920000;
      mem_ready = 1'b0;
      run = 1'b1;
      e = {fetch_step(0), fetch_step(1), fetch_step(1), fetch_step(1), fetch_step(1), fetch_step(2)};
      for (int i = 0; i < e.size(); i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== e[i]) begin
            $display("FAIL mem_wait cycle %0d: got %h expected %h", i, obs, e[i]);
            n_fail++;
         end
         mem_ready = (i >= 4);
      end
   endtask

   task automatic test_timeout();
      logic [52:0] e[$];
      do_reset();
      mem_ready = 1'b0;
      run = 1'b1;
      e.push_back(fetch_step(0));
      for (int k = 0; k < 16; k++) e.push_back(fetch_step(1));
      for (int k = 0; k < 3; k++) e.push_back(ex(14'h0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b1, 1'b0));
      for (int i = 0; i < e.size(); i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== e[i]) begin
            $display("FAIL timeout cycle %0d: got %h expected %h", i, obs, e[i]);
            n_fail++;
         end
         if (i >= 17) mem_ready = 1'b1;
      end
   endtask

   task automatic test_mul();
      logic [52:0] e[$];
      do_reset();
      ir = 32'h5A920000;
      run = 1'b1;
      e = {fetch_step(0), fetch_step(1), fetch_step(2),
           ex(B_Y_IN, 16'h0, 16'h0004, 4'h0, 1'b0, 1'b0, 1'b0),
           ex(B_Z_IN, 16'h0, 16'h0010, 4'h8, 1'b0, 1'b0, 1'b0),
           ex(B_ZLO | B_LO, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0),
           ex(B_ZHI | B_HI, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0),
           fetch_step(0)};
      for (int i = 0; i < e.size(); i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== e[i]) begin
            $display("FAIL mul cycle %0d: got %h expected %h", i, obs, e[i]);
            n_fail++;
         end
      end
   endtask

   task automatic test_neg();
      logic [52:0] e[$];
      do_reset();
      ir = 32'h6A900000;
      run = 1'b1;
      e = {fetch_step(0), fetch_step(1), fetch_step(2),
           ex(B_Z_IN, 16'h0, 16'h0004, 4'hA, 1'b0, 1'b0, 1'b0),
           ex(B_ZLO, 16'h0020, 16'h0, 4'h0, 1'b0, 1'b0, 1'b0),
           fetch_step(0)};
      for (int i = 0; i < e.size(); i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== e[i]) begin
            $display("FAIL neg cycle %0d: got %h expected %h", i, obs, e[i]);
            n_fail++;
         end
      end
   endtask

   task automatic test_nop_illegal();
      logic [52:0] e[$];
      do_reset();
      ir = 32'hF8000000;
      run = 1'b1;
      // Illegal opcode with run dropped during T3: pulse once, then park in IDLE.
      e = {fetch_step(0), fetch_step(1), fetch_step(2),
           ex(14'h0, 16'h0, 16'h0, 4'h0, 1'b0, 1'b0, 1'b1), 53'h0, 53'h0};
      for (int i = 0; i < e.size(); i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== e[i]) begin
            $display("FAIL illegal cycle %0d: got %h expected %h", i, obs, e[i]);
            n_fail++;
         end
         if (i == 2) run = 1'b0;
      end
      ir = 32'hD0000000;
      run = 1'b1;
      e = {fetch_step(0), fetch_step(1), fetch_step(2), 53'h0, fetch_step(0)};
      for (int i = 0; i < e.size(); i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== e[i]) begin
            $display("FAIL nop cycle %0d: got %h expected %h", i, obs, e[i]);
            n_fail++;
         end
      end
   endtask

   task automatic test_halt();
      logic [52:0] e[$];
      do_reset();
      ir = 32'hD8000000;
      run = 1'b1;
      e = {fetch_step(0), fetch_step(1), fetch_step(2), 53'h0};
      for (int k = 0; k < 4; k++) e.push_back(ex(14'h0, 16'h0, 16'h0, 4'h0, 1'b1, 1'b0, 1'b0));
      for (int i = 0; i < e.size(); i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== e[i]) begin
            $display("FAIL halt cycle %0d: got %h expected %h", i, obs, e[i]);
            n_fail++;
         end
      end
   endtask

   task automatic test_reset_mid();
      logic [52:0] e[$];
      do_reset();
      ir = 32'h1A920000;
      run = 1'b1;
      e = {fetch_step(0), fetch_step(1), fetch_step(2),
           ex(B_Y_IN, 16'h0, 16'h0004, 4'h0, 1'b0, 1'b0, 1'b0),
           ex(B_Z_IN, 16'h0, 16'h0010, 4'h2, 1'b0, 1'b0, 1'b0)};
      for (int i = 0; i < e.size(); i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== e[i]) begin
            $display("FAIL reset_mid_pre cycle %0d: got %h expected %h", i, obs, e[i]);
            n_fail++;
         end
      end
      reset = 1'b1;
      run = 1'b0;
      #1;
      n_checks++;
      if (obs !== 53'h0) begin
         $display("FAIL reset_mid_async: got %h expected %h", obs, 53'h0);
         n_fail++;
      end
      @(negedge clk);
      reset = 1'b0;
      e = {53'h0, 53'h0, 53'h0};
      for (int i = 0; i < e.size(); i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== e[i]) begin
            $display("FAIL reset_mid_idle cycle %0d: got %h expected %h", i, obs, e[i]);
            n_fail++;
         end
      end
      run = 1'b1;
      e = {fetch_step(0), fetch_step(1)};
      for (int i = 0; i < e.size(); i++) begin
         @(negedge clk);
         n_checks++;
         if (obs !== e[i]) begin
            $display("FAIL reset_mid_resume cycle %0d: got %h expected %h", i, obs, e[i]);
            n_fail++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_add();
      test_mem_wait();
      test_timeout();
      test_mul();
      test_neg();
      test_nop_illegal();
      test_halt();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
